fifo_queue_flagged: RTL and testbench

//  Parametrised single-clock FIFO queue, successor to the basic FIFO structure.

---
 rtl/fifo_queue_flagged.sv | 183 ++++++++++++++++++
 tb/tb_fifo_queue_flagged.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_queue_flagged.sv
`default_nettype none
// ============================================================================
// Module      : fifo_queue_flagged
// Description : Single-clock FIFO queue with simultaneous read/write,
//               registered status flags, occupancy count, sticky
//               overflow/underflow flags and an optional first-word-fall-
//               through output mode.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_queue_flagged #(
  parameter int data_width      = 8,
  parameter int FIFO_depth      = 8,
  parameter int almost_full_th  = 6,
  parameter int almost_empty_th = 2,
  parameter int FWFT            = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                write_enable,
  input  logic [data_width-1:0]               dataIn,
  input  logic                                read_enable,
  output logic [data_width-1:0]               dataOut,
  output logic                                data_valid,
  output logic                                full,
  output logic                                empty,
  output logic                                almost_full,
  output logic                                almost_empty,
  output logic [$clog2(FIFO_depth+1)-1:0]     count,
  output logic                                overflow,
  output logic                                underflow,
  input  logic                                clear_errors
);

  // Count must represent 0..FIFO_depth inclusive; pointers only 0..FIFO_depth-1.
  localparam int c_cnt_w = $clog2(FIFO_depth + 1);
  localparam int c_ptr_w = (FIFO_depth > 1) ? $clog2(FIFO_depth) : 1;

  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(FIFO_depth - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(FIFO_depth);
  localparam logic [c_cnt_w-1:0] c_af_th    = c_cnt_w'(almost_full_th);
  localparam logic [c_cnt_w-1:0] c_ae_th    = c_cnt_w'(almost_empty_th);

  // Storage (deliberately not reset)
  logic [data_width-1:0] mem_q [FIFO_depth];

  // Pointers, occupancy and flags
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               afull_q, afull_d;
  logic               aempty_q, aempty_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  // Transfer qualifiers, evaluated on pre-edge state
  logic rd_acc;
  logic wr_acc;

  // Pointer increment with wrap at FIFO_depth-1 (depth need not be a power of 2)
  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    if (p == c_ptr_last) begin
      return '0;
    end
    return p + c_ptr_w'(1);
  endfunction

  // A read is only taken from a non-empty queue; a write into a full queue is
  // taken only when a read frees the head slot in the same cycle.
  assign rd_acc = read_enable & ~empty_q;
  assign wr_acc = write_enable & (~full_q | rd_acc);

  // Next-state for pointers, occupancy, status and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (wr_acc) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (rd_acc) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + c_cnt_w'(1);
      2'b01:   count_d = count_q - c_cnt_w'(1);
      default: count_d = count_q;
    endcase

    // Flags derive from the next count so they line up with count every cycle.
    full_d   = (count_d == c_cnt_full);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= c_af_th);
    aempty_d = (count_d <= c_ae_th);

    // Clear first so that a simultaneous new error wins.
    if (clear_errors) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (write_enable & ~wr_acc) begin
      ovf_d = 1'b1;
    end
    if (read_enable & empty_q) begin
      unf_d = 1'b1;
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= dataIn;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while empty so the output is
      // clean after reset even though the storage itself is not reset.
      assign dataOut    = empty_q ? '0 : mem_q[rd_ptr_q];
      assign data_valid = ~empty_q;
    end else begin : g_reg_read
      logic [data_width-1:0] dout_q;
      logic                  dv_q;

      // Registered read port: data_valid pulses for one cycle after each pop
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else begin
          dv_q <= rd_acc;
          if (rd_acc) begin
            dout_q <= mem_q[rd_ptr_q];
          end
        end
      end

      assign dataOut    = dout_q;
      assign data_valid = dv_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_queue_flagged.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_queue_flagged
// Description : Directed self-checking bench for fifo_queue_flagged, with one
//               registered-read instance and one FWFT instance on shared inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_queue_flagged;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n        = 1'b1;
  logic       write_enable = 1'b0;
  logic       read_enable  = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] dataIn       = 8'h00;

  logic [7:0] d0_dout, d1_dout;
  logic       d0_dv, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic       d1_dv, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [3:0] d0_cnt, d1_cnt;

  fifo_queue_flagged #(
    .data_width(8), .FIFO_depth(8), .almost_full_th(6), .almost_empty_th(2), .FWFT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .dataIn(dataIn),
    .read_enable(read_enable), .dataOut(d0_dout), .data_valid(d0_dv),
    .full(d0_full), .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
    .count(d0_cnt), .overflow(d0_ovf), .underflow(d0_unf), .clear_errors(clear_errors)
  );

  fifo_queue_flagged #(
    .data_width(8), .FIFO_depth(8), .almost_full_th(6), .almost_empty_th(2), .FWFT(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .dataIn(dataIn),
    .read_enable(read_enable), .dataOut(d1_dout), .data_valid(d1_dv),
    .full(d1_full), .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
    .count(d1_cnt), .overflow(d1_ovf), .underflow(d1_unf), .clear_errors(clear_errors)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic we, input logic re, input logic ce, input logic [7:0] d);
    write_enable = we;
    read_enable  = re;
    clear_errors = ce;
    dataIn       = d;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    clear_errors = 1'b0;
  endtask

  task automatic chk_rst(input string tg);
    chk({tg, "_cnt0"},  d0_cnt,   0);
    chk({tg, "_emp0"},  d0_empty, 1);
    chk({tg, "_ae0"},   d0_ae,    1);
    chk({tg, "_full0"}, d0_full,  0);
    chk({tg, "_af0"},   d0_af,    0);
    chk({tg, "_ovf0"},  d0_ovf,   0);
    chk({tg, "_unf0"},  d0_unf,   0);
    chk({tg, "_dv0"},   d0_dv,    0);
    chk({tg, "_dout0"}, d0_dout,  0);
    chk({tg, "_cnt1"},  d1_cnt,   0);
    chk({tg, "_emp1"},  d1_empty, 1);
    chk({tg, "_dv1"},   d1_dv,    0);
    chk({tg, "_dout1"}, d1_dout,  0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] e;

    // Reset
    #2 rst_n = 1'b0;
    #1 chk_rst("por");
    #5 rst_n = 1'b1;

    // T1: fill, almost_full from the 6th write, overflow on the 9th
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
      chk("t1_cnt",  d0_cnt,  i + 1);
      chk("t1_af",   d0_af,   (i >= 5));
      chk("t1_ae",   d0_ae,   (i <= 1));
      chk("t1_full", d0_full, (i == 7));
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h99);
    chk("t1_ovf",   d0_ovf, 1);
    chk("t1_cnt9",  d0_cnt, 8);
    chk("t1_unf",   d0_unf, 0);

    // T2: drain in order, then underflow on an extra read
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t2_dout", d0_dout, 8'h10 + i);
      chk("t2_dv",   d0_dv,   1);
      chk("t2_cnt",  d0_cnt,  7 - i);
    end
    chk("t2_empty", d0_empty, 1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t2_dv_idle",   d0_dv,   0);
    chk("t2_dout_hold", d0_dout, 8'h17);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t2_unf",      d0_unf,  1);
    chk("t2_dv_rej",   d0_dv,   0);
    chk("t2_dout_rej", d0_dout, 8'h17);
    chk("t2_cnt_rej",  d0_cnt,  0);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("t2_clr_ovf", d0_ovf, 0);
    chk("t2_clr_unf", d0_unf, 0);

    // T3: read+write while full
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    chk("t3_full", d0_full, 1);
    cyc(1'b1, 1'b1, 1'b0, 8'hAA);
    chk("t3_cnt",   d0_cnt,  8);
    chk("t3_ovf",   d0_ovf,  0);
    chk("t3_full2", d0_full, 1);
    chk("t3_dout",  d0_dout, 8'h20);
    chk("t3_dv",    d0_dv,   1);
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t3_old", d0_dout, 8'h20 + i);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t3_last",  d0_dout,  8'hAA);
    chk("t3_empty", d0_empty, 1);

    // T4: read+write while empty
    cyc(1'b1, 1'b1, 1'b0, 8'h55);
    chk("t4_unf",   d0_unf,   1);
    chk("t4_cnt",   d0_cnt,   1);
    chk("t4_dv",    d0_dv,    0);
    chk("t4_hold",  d0_dout,  8'hAA);
    chk("t4_empty", d0_empty, 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t4_dout", d0_dout, 8'h55);
    chk("t4_dv2",  d0_dv,   1);
    chk("t4_cnt2", d0_cnt,  0);

    // T5: steady-state read+write around count 4, pointers wrap
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h30 + i);
      model.push_back(d);
      cyc(1'b1, 1'b0, 1'b0, d);
    end
    for (int i = 0; i < 20; i++) begin
      d = 8'(8'h40 + i);
      e = model.pop_front();
      model.push_back(d);
      cyc(1'b1, 1'b1, 1'b0, d);
      chk("t5_dout", d0_dout, e);
      chk("t5_cnt",  d0_cnt,  4);
    end
    while (model.size() > 0) begin
      e = model.pop_front();
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t5_drain", d0_dout, e);
    end
    chk("t5_unf_sticky", d0_unf, 1);
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    chk("t5_set_wins", d0_unf, 1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("t5_clr_unf", d0_unf, 0);
    chk("t5_clr_ovf", d0_ovf, 0);

    // T6: FWFT behaviour and asynchronous reset mid-stream
    chk("t6_dout_e", d1_dout, 8'h00);
    chk("t6_dv_e",   d1_dv,   0);
    cyc(1'b1, 1'b0, 1'b0, 8'h3C);
    chk("t6_dout1",  d1_dout, 8'h3C);
    chk("t6_dv1",    d1_dv,   1);
    chk("t6_dv0",    d0_dv,   0);
    cyc(1'b1, 1'b0, 1'b0, 8'h3D);
    chk("t6_head",   d1_dout, 8'h3C);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t6_next",   d1_dout, 8'h3D);
    chk("t6_dv_nx",  d1_dv,   1);
    chk("t6_reg",    d0_dout, 8'h3C);
    write_enable = 1'b1;
    dataIn       = 8'h3E;
    #3 rst_n = 1'b0;
    #1 chk_rst("t6_arst");
    @(posedge clk);
    #1 chk_rst("t6_hold");
    write_enable = 1'b0;
    rst_n        = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
